// File: rtl/vid_timing_pkg.sv
// Shared types and constants for the parametrised video timing generator:
// FSM state encoding, colour-bar palette and counter sizing.
package vid_timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        logic [23:0] c;
        case (bar)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

    // Width of a counter that must reach total-1; never narrower than one bit.
    function automatic int cnt_width(input int total);
        return (total > 2) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vid_timing_gen_delay.sv
// vid_delay_line: DEPTH-stage register pipeline with asynchronous reset to
// RST_VAL; DEPTH=0 degenerates to a plain wire.
module vid_delay_line #(
    parameter int              WIDTH   = 1,
    parameter int              DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vid_timing_gen.sv
// Parametrised video timing generator with early FIFO reads, frame-boundary
// run control and underflow counting. Optional colour bars: TEST_PATTERN_EN.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int DATA_WIDTH = 32,
    parameter int PIX_WIDTH  = 24,
    parameter int RD_LAT     = 1,
    parameter int UF_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_empty,
`ifdef TEST_PATTERN_EN
    input  logic                  test_pat,
`endif
    output logic                  pix_req,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  pix_valid,
    output logic [PIX_WIDTH-1:0]  rgb_out,
    output logic                  frame_start,
    output logic                  busy,
    output logic [UF_CNT_W-1:0]   underflow_cnt
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   H_CW    = cnt_width(H_TOTAL);
    localparam int   V_CW    = cnt_width(V_TOTAL);
    localparam logic HS_ACT  = (HS_POL != 0);
    localparam logic VS_ACT  = (VS_POL != 0);
    localparam logic [4:0] CTL_RST = {1'b0, 1'b0, ~VS_ACT, ~HS_ACT, 1'b0};

    state_t          state;
    logic [H_CW-1:0] h_cnt;
    logic [V_CW-1:0] v_cnt;
    logic            h_last, v_last, running, act, hs_win, vs_win, pat;

    assign h_last  = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last  = (int'(v_cnt) == V_TOTAL - 1);
    assign running = (state != IDLE);
    assign busy    = running;

`ifdef TEST_PATTERN_EN
    assign pat = test_pat;
`else
    assign pat = 1'b0;
`endif

    // Run control only changes the frame cadence at the last position, so a
    // started frame always completes; DRAIN -> RUN leaves the counters alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (!en) state <= (h_last && v_last) ? IDLE : DRAIN;
                DRAIN: begin
                    if (h_last && v_last) state <= en ? RUN : IDLE;
                    else if (en)          state <= RUN;
                end
                default: state <= IDLE;
            endcase

            if (state == IDLE) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign act    = running && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hs_win = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_win = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

    // FIFO handshake: pix_req is a one-clock read strobe with no back-pressure;
    // pix_empty is sampled in the same cycle, and data for a non-empty request
    // is presented on pix_in exactly RD_LAT clocks after the strobe.
    logic hs1, vs1, de1, fs1, uf1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_req <= 1'b0;
            hs1     <= ~HS_ACT;
            vs1     <= ~VS_ACT;
            de1     <= 1'b0;
            fs1     <= 1'b0;
        end else begin
            pix_req <= act && !pat;
            hs1     <= (running && hs_win) ? HS_ACT : ~HS_ACT;
            vs1     <= (running && vs_win) ? VS_ACT : ~VS_ACT;
            de1     <= act;
            fs1     <= running && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign uf1 = pix_req && pix_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                underflow_cnt <= '0;
        else if (uf1 && !(&underflow_cnt))      underflow_cnt <= underflow_cnt + 1'b1;
    end

    // RD_LAT stages here plus the output register below give RD_LAT+1 clocks
    // from pix_req, with de/uf arriving alongside the matching pix_in word.
    logic [4:0] ctl_d;
    logic       hs_d, vs_d, de_d, fs_d, uf_d;

    vid_delay_line #(
        .WIDTH   (5),
        .DEPTH   (RD_LAT),
        .RST_VAL (CTL_RST)
    ) u_ctl_dly (
        .clk (clk),
        .rst (rst),
        .d   ({fs1, de1, vs1, hs1, uf1}),
        .q   (ctl_d)
    );

    assign {fs_d, de_d, vs_d, hs_d, uf_d} = ctl_d;

    logic [PIX_WIDTH-1:0] pix_next;
    logic                 unused_pix;
    assign unused_pix = &{1'b0, pix_in};

`ifdef TEST_PATTERN_EN
    logic [H_CW-1:0] h1, h_d;
    logic [2:0]      bar_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) h1 <= '0;
        else     h1 <= h_cnt;
    end

    vid_delay_line #(
        .WIDTH   (H_CW),
        .DEPTH   (RD_LAT),
        .RST_VAL ('0)
    ) u_h_dly (
        .clk (clk),
        .rst (rst),
        .d   (h1),
        .q   (h_d)
    );

    assign bar_idx = 3'((int'(h_d) * 8) / H_ACTIVE);
`endif

    always_comb begin
        pix_next = (de_d && !uf_d) ? pix_in[DATA_WIDTH-1 -: PIX_WIDTH] : '0;
`ifdef TEST_PATTERN_EN
        if (pat) pix_next = de_d ? PIX_WIDTH'(bar_colour(bar_idx)) : '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            rgb_out     <= '0;
        end else begin
            hsync       <= hs_d;
            vsync       <= vs_d;
            pix_valid   <= de_d;
            frame_start <= fs_d;
            rgb_out     <= pix_next;
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen in a 14x7 mode with RD_LAT=1; a second
// instance with a 2-bit underflow counter covers saturation.
module tb_vid_timing_gen;

    logic        clk, rst, en, pix_empty;
    logic [31:0] pix_in;
`ifdef TEST_PATTERN_EN
    logic        test_pat;
`endif
    logic        pix_req, hsync, vsync, pix_valid, frame_start, busy;
    logic [23:0] rgb_out;
    logic [15:0] underflow_cnt;
    logic        sat_pix_req, sat_hsync, sat_vsync, sat_pix_valid, sat_frame_start, sat_busy;
    logic [23:0] sat_rgb_out;
    logic [1:0]  sat_underflow_cnt;

    int errors = 0;
    int checks = 0;

    vid_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .DATA_WIDTH(32), .PIX_WIDTH(24),
        .RD_LAT(1), .UF_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pix_in(pix_in), .pix_empty(pix_empty),
`ifdef TEST_PATTERN_EN
        .test_pat(test_pat),
`endif
        .pix_req(pix_req), .hsync(hsync), .vsync(vsync), .pix_valid(pix_valid),
        .rgb_out(rgb_out), .frame_start(frame_start), .busy(busy),
        .underflow_cnt(underflow_cnt)
    );

    vid_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .DATA_WIDTH(32), .PIX_WIDTH(24),
        .RD_LAT(1), .UF_CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .en(en), .pix_in(pix_in), .pix_empty(pix_empty),
`ifdef TEST_PATTERN_EN
        .test_pat(test_pat),
`endif
        .pix_req(sat_pix_req), .hsync(sat_hsync), .vsync(sat_vsync), .pix_valid(sat_pix_valid),
        .rgb_out(sat_rgb_out), .frame_start(sat_frame_start), .busy(sat_busy),
        .underflow_cnt(sat_underflow_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: RD_LAT=1, word = index << 8, empty requests return nothing.
    int          fifo_idx   = 0;
    int          empty_left = 0;
    int          req_total  = 0;
    logic        pend       = 1'b0;
    logic [31:0] pend_data  = '0;
    logic [23:0] exp_q[$];

    initial begin
        pix_in    = 32'hA5A5_A5A5;
        pix_empty = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pix_in    = pend ? pend_data : 32'hA5A5_A5A5;
            pend      = 1'b0;
            pix_empty = (empty_left > 0);
            if (pix_req === 1'b1) begin
                req_total++;
                if (pix_empty) begin
                    empty_left--;
                    exp_q.push_back(24'h0);
                end else begin
                    pend      = 1'b1;
                    pend_data = fifo_idx << 8;
                    exp_q.push_back(24'(fifo_idx));
                    fifo_idx++;
                end
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        fifo_idx   = 0;
        empty_left = 0;
        req_total  = 0;
        pend       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_model();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_fs(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 20);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL %s: frame_start after %0d clocks, required 4", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({pix_req, pix_valid, frame_start, busy, hsync, vsync} !== 6'b000011) begin
            errors++;
            $display("FAIL reset_ctl: got %b required 000011",
                     {pix_req, pix_valid, frame_start, busy, hsync, vsync});
        end
        checks++;
        if (rgb_out !== 24'h0) begin
            errors++;
            $display("FAIL reset_rgb: got %h required 000000", rgb_out);
        end
        checks++;
        if (underflow_cnt !== 16'h0 || sat_underflow_cnt !== 2'h0) begin
            errors++;
            $display("FAIL reset_uf: got %0d/%0d required 0/0", underflow_cnt, sat_underflow_cnt);
        end
    endtask

    task automatic test_timing();
        int n, hp, vp, p2, rq;
        logic [4:0] exp_v, got_v;
        do_reset();
        en = 1'b1;
        wait_fs("timing_fs_latency", n);
        hp = 0; vp = 0; rq = 0;
        for (int c = 0; c < 2 * 98; c++) begin
            p2    = (vp * 14 + hp + 2) % 98;
            exp_v = {(hp < 8) && (vp < 4), !(hp == 10 || hp == 11), vp != 5,
                     hp == 0 && vp == 0, (p2 % 14 < 8) && (p2 / 14 < 4)};
            got_v = {pix_valid, hsync, vsync, frame_start, pix_req};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL timing h=%0d v=%0d: {valid,hs,vs,fs,req} got %b required %b",
                         hp, vp, got_v, exp_v);
            end
            if (pix_req === 1'b1) rq++;
            @(negedge clk);
            hp++;
            if (hp == 14) begin hp = 0; vp++; if (vp == 7) vp = 0; end
            if (hp == 0 && vp == 0) begin
                checks++;
                if (rq != 32) begin
                    errors++;
                    $display("FAIL req_per_frame: got %0d required 32", rq);
                end
                rq = 0;
            end
        end
    endtask

    task automatic test_frame_data();
        int n, k;
        do_reset();
        en = 1'b1;
        wait_fs("data_fs_latency", n);
        k = 0;
        for (int c = 0; c < 98; c++) begin
            checks++;
            if (pix_valid === 1'b1) begin
                if (rgb_out !== 24'(k)) begin
                    errors++;
                    $display("FAIL frame_data pixel %0d: got %h required %h", k, rgb_out, 24'(k));
                end
                k++;
            end else if (rgb_out !== 24'h0) begin
                errors++;
                $display("FAIL blanking: got %h required 000000", rgb_out);
            end
            @(negedge clk);
        end
        checks++;
        if (k != 32) begin
            errors++;
            $display("FAIL frame_pixels: got %0d required 32", k);
        end
    endtask

    task automatic test_drain();
        int vc;
        do_reset();
        en = 1'b1;
        vc = 0;
        for (int e = 1; e <= 18; e++) begin
            @(negedge clk);
            if (pix_valid === 1'b1) vc++;
        end
        en = 1'b0;  // edge 19 samples en=0 with counters at h=3, v=1
        for (int e = 19; e <= 98; e++) begin
            @(negedge clk);
            if (pix_valid === 1'b1) vc++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_last_pos: got %b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle: got %b required 0", busy);
        end
        repeat (6) begin
            @(negedge clk);
            if (pix_valid === 1'b1) vc++;
        end
        checks++;
        if (req_total != 32 || vc != 32) begin
            errors++;
            $display("FAIL drain_frame: req=%0d valid=%0d required 32/32", req_total, vc);
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({pix_req, pix_valid, frame_start, busy, hsync, vsync} !== 6'b000011 || rgb_out !== 24'h0) begin
                errors++;
                $display("FAIL idle_outputs: got %b rgb=%h required 000011 rgb=000000",
                         {pix_req, pix_valid, frame_start, busy, hsync, vsync}, rgb_out);
            end
            @(negedge clk);
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_e1: req=%b busy=%b required 0/1", pix_req, busy);
        end
        @(negedge clk);
        checks++;
        if (pix_req !== 1'b1) begin
            errors++;
            $display("FAIL restart_e2: req=%b required 1", pix_req);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart_fs: fs=%b valid=%b required 1/1", frame_start, pix_valid);
        end
    endtask

    task automatic test_drain_resume();
        int n, bad_fs, busy_lo;
        do_reset();
        en = 1'b1;
        wait_fs("resume_fs_latency", n);
        bad_fs = 0; busy_lo = 0;
        for (int c = 1; c <= 196; c++) begin
            @(negedge clk);
            if (c == 20) en = 1'b0;
            if (c == 30) en = 1'b1;
            if (busy !== 1'b1) busy_lo++;
            if (c == 98 || c == 196) begin
                checks++;
                if (frame_start !== 1'b1) begin
                    errors++;
                    $display("FAIL resume_fs_period at %0d: got %b required 1", c, frame_start);
                end
            end else if (frame_start !== 1'b0) begin
                bad_fs++;
            end
        end
        checks++;
        if (bad_fs != 0 || busy_lo != 0) begin
            errors++;
            $display("FAIL resume_stable: stray_fs=%0d busy_low=%0d required 0/0", bad_fs, busy_lo);
        end
    endtask

    task automatic test_underflow();
        int n, k;
        logic [23:0] exp_px;
        do_reset();
        fifo_idx   = 100;
        empty_left = 5;
        en = 1'b1;
        wait_fs("uf_fs_latency", n);
        k = 0;
        for (int c = 0; c < 98; c++) begin
            if (pix_valid === 1'b1) begin
                exp_px = (k < 5) ? 24'h0 : 24'(100 + k - 5);
                checks++;
                if (rgb_out !== exp_px) begin
                    errors++;
                    $display("FAIL underflow_pixel %0d: got %h required %h", k, rgb_out, exp_px);
                end
                k++;
            end
            @(negedge clk);
        end
        checks++;
        if (k != 32) begin
            errors++;
            $display("FAIL underflow_valid: got %0d valid pixels required 32", k);
        end
        checks++;
        if (underflow_cnt !== 16'd5) begin
            errors++;
            $display("FAIL underflow_cnt: got %0d required 5", underflow_cnt);
        end
        checks++;
        if (sat_underflow_cnt !== 2'd3) begin
            errors++;
            $display("FAIL underflow_sat: got %0d required 3", sat_underflow_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n, k;
        logic [23:0] exp_px;
        do_reset();
        en = 1'b1;
        wait_fs("b2b_fs_latency", n);
        k = 0;
        for (int c = 0; c < 3 * 98; c++) begin
            if (c == 120) empty_left = 3;
            if (pix_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_queue: pixel %0d with no expected entry", k);
                end else begin
                    exp_px = exp_q.pop_front();
                    if (rgb_out !== exp_px) begin
                        errors++;
                        $display("FAIL b2b_pixel %0d: got %h required %h", k, rgb_out, exp_px);
                    end
                end
                k++;
            end
            @(negedge clk);
        end
        checks++;
        if (k != 96 || underflow_cnt !== 16'd3 || sat_underflow_cnt !== 2'd3) begin
            errors++;
            $display("FAIL b2b_totals: pixels=%0d uf=%0d sat=%0d required 96/3/3",
                     k, underflow_cnt, sat_underflow_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n, bad;
        do_reset();
        en = 1'b1;
        wait_fs("mid_fs_latency", n);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pix_req, pix_valid, frame_start, busy, hsync, vsync} !== 6'b000011 ||
            rgb_out !== 24'h0 || underflow_cnt !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got %b rgb=%h uf=%0d required 000011 rgb=000000 uf=0",
                     {pix_req, pix_valid, frame_start, busy, hsync, vsync}, rgb_out, underflow_cnt);
        end
        @(negedge clk);
        clear_model();
        rst = 1'b0;
        wait_fs("mid_restart_latency", n);
        bad = 0;
        for (int c = 1; c <= 98; c++) begin
            @(negedge clk);
            if (c < 98 && frame_start !== 1'b0) bad++;
        end
        checks++;
        if (frame_start !== 1'b1 || bad != 0) begin
            errors++;
            $display("FAIL mid_restart_period: fs=%b stray=%0d required 1/0", frame_start, bad);
        end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        int n, hp, vp, reqs;
        logic [23:0] bars [8];
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        test_pat = 1'b1;
        do_reset();
        en = 1'b1;
        wait_fs("pat_fs_latency", n);
        hp = 0; vp = 0; reqs = 0;
        for (int c = 0; c < 98; c++) begin
            if (pix_req !== 1'b0) reqs++;
            if (pix_valid === 1'b1) begin
                checks++;
                if (rgb_out !== bars[hp]) begin
                    errors++;
                    $display("FAIL pattern h=%0d v=%0d: got %h required %h", hp, vp, rgb_out, bars[hp]);
                end
            end
            @(negedge clk);
            hp++;
            if (hp == 14) begin hp = 0; vp++; end
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL pattern_req: got %0d requests required 0", reqs);
        end
        test_pat = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        en  = 1'b0;
`ifdef TEST_PATTERN_EN
        test_pat = 1'b0;
`endif
        test_reset();
        test_timing();
        test_frame_data();
        test_drain();
        test_drain_resume();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
